taillight_seq_monitor: RTL and testbench

//  Passive checker/decoder for the six tail-light lamp outputs of the turn-signal sequencer.

---
 rtl/taillight_seq_monitor.sv | 118 +++++++++++
 tb/tb_taillight_seq_monitor.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/taillight_seq_monitor.sv
// Passive monitor for the turn-signal sequencer's six tail-light lamps.
// Each side is tracked independently through 000->001->011->111->000.
// The monitor reports completed sequences, sticky illegal-transition flags,
// saturating completion counts, and simultaneous (hazard) completions.
module taillight_seq_monitor #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             LA,
  input  logic             LB,
  input  logic             LC,
  input  logic             RA,
  input  logic             RB,
  input  logic             RC,
  output logic             l_done,
  output logic             r_done,
  output logic             hazard,
  output logic             l_err,
  output logic             r_err,
  output logic [CNT_W-1:0] l_cnt,
  output logic [CNT_W-1:0] r_cnt,
  output logic [1:0]       l_phase,
  output logic [1:0]       r_phase
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } state_t;

  typedef struct packed {
    state_t nxt;
    logic   done;
    logic   bad;
  } step_t;

  // One tracker step. Any illegal pattern resyncs to S1 on 001, else IDLE,
  // so a default of "illegal" is set first and legal moves override it.
  function automatic step_t track(input state_t s, input logic [2:0] p);
    step_t r;
    r.nxt  = (p == 3'b001) ? S1 : IDLE;
    r.done = 1'b0;
    r.bad  = 1'b1;
    case (s)
      IDLE: if (p == 3'b000 || p == 3'b001) r.bad = 1'b0;
      S1:   if (p == 3'b011) begin r.nxt = S2; r.bad = 1'b0; end
      S2:   if (p == 3'b111) begin r.nxt = S3; r.bad = 1'b0; end
      S3:   if (p == 3'b000) begin r.nxt = IDLE; r.bad = 1'b0; r.done = 1'b1; end
      default: ;
    endcase
    return r;
  endfunction

  state_t     l_state, r_state;
  step_t      l_step, r_step;
  logic [2:0] l_pat, r_pat;

  assign l_pat   = {LC, LB, LA};
  assign r_pat   = {RC, RB, RA};
  assign l_phase = l_state;
  assign r_phase = r_state;

  // Next-state and event decode for both sides from this edge's lamp pattern.
  always_comb begin
    l_step = '0;
    r_step = '0;
    l_step = track(l_state, l_pat);
    r_step = track(r_state, r_pat);
  end

  // Tracker state and one-cycle event pulses; clr leaves these untouched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_state <= IDLE;
      r_state <= IDLE;
      l_done  <= 1'b0;
      r_done  <= 1'b0;
      hazard  <= 1'b0;
    end else begin
      l_state <= l_step.nxt;
      r_state <= r_step.nxt;
      l_done  <= l_step.done;
      r_done  <= r_step.done;
      hazard  <= l_step.done & r_step.done;
    end
  end

  // Sticky error flags: a new error on the clearing edge takes priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_err <= 1'b0;
      r_err <= 1'b0;
    end else begin
      if (l_step.bad)  l_err <= 1'b1;
      else if (clr)    l_err <= 1'b0;
      if (r_step.bad)  r_err <= 1'b1;
      else if (clr)    r_err <= 1'b0;
    end
  end

  // Saturating completion counters; clr beats a same-edge increment.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      l_cnt <= '0;
      r_cnt <= '0;
    end else begin
      if (clr)                              l_cnt <= '0;
      else if (l_step.done && l_cnt != '1)  l_cnt <= l_cnt + 1'b1;
      if (clr)                              r_cnt <= '0;
      else if (r_step.done && r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_taillight_seq_monitor.sv
// Directed-vector bench for taillight_seq_monitor. A second instance with
// CNT_W=2 shares all inputs so counter saturation can be observed.
module tb_taillight_seq_monitor;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic LA = 1'b0, LB = 1'b0, LC = 1'b0;
  logic RA = 1'b0, RB = 1'b0, RC = 1'b0;

  logic       l_done, r_done, hazard, l_err, r_err;
  logic [7:0] l_cnt, r_cnt;
  logic [1:0] l_phase, r_phase;

  logic       l_done2, r_done2, hazard2, l_err2, r_err2;
  logic [1:0] l_cnt2, r_cnt2;
  logic [1:0] l_phase2, r_phase2;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  taillight_seq_monitor #(.CNT_W(8)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .LA(LA), .LB(LB), .LC(LC), .RA(RA), .RB(RB), .RC(RC),
    .l_done(l_done), .r_done(r_done), .hazard(hazard),
    .l_err(l_err), .r_err(r_err), .l_cnt(l_cnt), .r_cnt(r_cnt),
    .l_phase(l_phase), .r_phase(r_phase)
  );

  taillight_seq_monitor #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .clr(clr),
    .LA(LA), .LB(LB), .LC(LC), .RA(RA), .RB(RB), .RC(RC),
    .l_done(l_done2), .r_done(r_done2), .hazard(hazard2),
    .l_err(l_err2), .r_err(r_err2), .l_cnt(l_cnt2), .r_cnt(r_cnt2),
    .l_phase(l_phase2), .r_phase(r_phase2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive patterns after the falling edge, then sample 1 time unit past the rising edge.
  task automatic step(input logic [2:0] pl, input logic [2:0] pr, input logic c);
    @(negedge clk);
    {LC, LB, LA} = pl;
    {RC, RB, RA} = pr;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_all(input string tag);
    check({tag, "_ldone"}, l_done, 0);
    check({tag, "_rdone"}, r_done, 0);
    check({tag, "_haz"}, hazard, 0);
    check({tag, "_lerr"}, l_err, 0);
    check({tag, "_rerr"}, r_err, 0);
    check({tag, "_lcnt"}, l_cnt, 0);
    check({tag, "_rcnt"}, r_cnt, 0);
    check({tag, "_lph"}, l_phase, 0);
    check({tag, "_rph"}, r_phase, 0);
  endtask

  initial begin
    // 1: reset and idle
    repeat (2) @(posedge clk);
    #1;
    check_idle_all("rst");
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) step(3'b000, 3'b000, 1'b0);
    check_idle_all("idle");

    // 2: one legal left sequence
    step(3'b001, 3'b000, 1'b0); check("t2_ph1", l_phase, 1);
    step(3'b011, 3'b000, 1'b0); check("t2_ph2", l_phase, 2);
    step(3'b111, 3'b000, 1'b0); check("t2_ph3", l_phase, 3); check("t2_nodone", l_done, 0);
    step(3'b000, 3'b000, 1'b0);
    check("t2_ph0", l_phase, 0); check("t2_done", l_done, 1); check("t2_cnt", l_cnt, 1);
    check("t2_haz", hazard, 0); check("t2_rdone", r_done, 0); check("t2_rcnt", r_cnt, 0);
    check("t2_lerr", l_err, 0); check("t2_rerr", r_err, 0);
    step(3'b000, 3'b000, 1'b0); check("t2_pulse1", l_done, 0);

    // 3: skipped left step, repeated right step (resync to S1), clr
    step(3'b001, 3'b001, 1'b0); check("t3_lph1", l_phase, 1); check("t3_rph1", r_phase, 1);
    step(3'b111, 3'b001, 1'b0);
    check("t3_lerr", l_err, 1); check("t3_lph0", l_phase, 0); check("t3_ldone", l_done, 0);
    check("t3_rerr", r_err, 1); check("t3_rresync", r_phase, 1);
    step(3'b001, 3'b011, 1'b0);
    check("t3_lph_r", l_phase, 1); check("t3_lerr_stk", l_err, 1); check("t3_rph2", r_phase, 2);
    step(3'b011, 3'b111, 1'b1);
    check("t3_clr_lerr", l_err, 0); check("t3_clr_rerr", r_err, 0);
    check("t3_clr_lcnt", l_cnt, 0); check("t3_lph2", l_phase, 2); check("t3_rph3", r_phase, 3);
    step(3'b111, 3'b000, 1'b0);
    check("t3_rdone", r_done, 1); check("t3_rcnt", r_cnt, 1); check("t3_haz0", hazard, 0);
    check("t3_lph3", l_phase, 3);
    step(3'b000, 3'b000, 1'b0);
    check("t3_ldone", l_done, 1); check("t3_rdone0", r_done, 0); check("t3_lcnt", l_cnt, 1);

    // 4: hazard
    step(3'b000, 3'b000, 1'b1);
    check("t4_clr_l", l_cnt, 0); check("t4_clr_r", r_cnt, 0);
    step(3'b001, 3'b001, 1'b0);
    step(3'b011, 3'b011, 1'b0);
    step(3'b111, 3'b111, 1'b0); check("t4_haz_early", hazard, 0);
    step(3'b000, 3'b000, 1'b0);
    check("t4_ldone", l_done, 1); check("t4_rdone", r_done, 1); check("t4_haz", hazard, 1);
    check("t4_lcnt", l_cnt, 1); check("t4_rcnt", r_cnt, 1);
    step(3'b000, 3'b000, 1'b0); check("t4_haz_pulse", hazard, 0);

    // 5: five back-to-back left sequences, saturation at CNT_W=2
    step(3'b000, 3'b000, 1'b1);
    check("t5_clr2", l_cnt2, 0);
    for (int n = 0; n < 5; n++) begin
      step(3'b001, 3'b000, 1'b0);
      check($sformatf("t5_ph1_%0d", n), l_phase2, 1);
      check($sformatf("t5_gap_%0d", n), l_done2, 0);
      step(3'b011, 3'b000, 1'b0);
      step(3'b111, 3'b000, 1'b0);
      step(3'b000, 3'b000, 1'b0);
      if (l_done2) pulses++;
      check($sformatf("t5_cnt_%0d", n), l_cnt2, (n < 3) ? n + 1 : 3);
    end
    check("t5_pulses", pulses, 5);
    check("t5_err", l_err2, 0);
    check("t5_cnt8", l_cnt, 5);

    // 6: clr on the done edge, then reset mid-sequence
    step(3'b001, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0);
    step(3'b111, 3'b000, 1'b0);
    step(3'b000, 3'b000, 1'b1);
    check("t6_done_clr", l_done, 1); check("t6_cnt_clr", l_cnt, 0);
    step(3'b001, 3'b000, 1'b0);
    step(3'b011, 3'b000, 1'b0); check("t6_ph2", l_phase, 2);
    #2 reset = 1'b0;
    #1 check("t6_async_ph", l_phase, 0);
    @(negedge clk);
    {LC, LB, LA} = 3'b111;
    clr = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t6_resid_err", l_err, 1); check("t6_resid_ph", l_phase, 0);
    check("t6_resid_done", l_done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
